// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timer.
// Provides the phase encoding and an elaboration-time binary-to-BCD helper
// that builds the per-phase countdown load constants.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_GREEN   = 2'd0,
      PH_YELLOW  = 2'd1,
      PH_RED     = 2'd2,
      PH_ILLEGAL = 2'd3
   } phase_e;

   localparam int MAX_DIGITS = 4;

   // Packs a non-negative integer into MAX_DIGITS BCD nibbles, LS digit in [3:0].
   function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
      logic [4*MAX_DIGITS-1:0] bcd;
      int                      v;
      bcd = '0;
      v   = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         bcd[4*i +: 4] = 4'(v % 10);
         v             = v / 10;
      end
      return bcd;
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter.
// Ports:
//   CLK         system clock
//   i_clr       synchronous clear to RST_VAL (highest priority)
//   i_load      load i_load_val (beats i_dec)
//   i_load_val  BCD value to load
//   i_dec       decrement by one with BCD borrow
//   o_bcd       current BCD value, digit 0 in [3:0]
//   o_zero      high when every digit is 0
module bcd_down_counter
   import traffic_pkg::*;
#(
   parameter int                  DIGITS  = 2,
   parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
   input  logic                CLK,
   input  logic                i_clr,
   input  logic                i_load,
   input  logic [4*DIGITS-1:0] i_load_val,
   input  logic                i_dec,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic                o_zero
);

   if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_chk_digits
      $error("bcd_down_counter: DIGITS out of range");
   end

   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_dec_val;
   logic                w_borrow;

   // Ripple borrow: a 0 digit wraps to 9 and passes the borrow upward.
   always_comb begin
      w_dec_val = r_bcd;
      w_borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_borrow) begin
            if (r_bcd[4*i +: 4] == 4'd0) begin
               w_dec_val[4*i +: 4] = 4'd9;
            end else begin
               w_dec_val[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
               w_borrow            = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (i_clr) begin
         r_bcd <= RST_VAL;
      end else if (i_load) begin
         r_bcd <= i_load_val;
      end else if (i_dec) begin
         r_bcd <= w_dec_val;
      end
   end

   assign o_bcd  = r_bcd;
   assign o_zero = (r_bcd == '0);

endmodule

// File: rtl/traffic_light_timer.sv
// Three-phase traffic-light timer with BCD countdown of remaining seconds.
// Ports:
//   CLK          system clock
//   CLR          synchronous active-high reset
//   EN           run enable; low freezes prescaler and countdown
//   PED_REQ      pedestrian request, level sampled every edge
//   digits       BCD seconds remaining in the phase, digit 0 in [3:0]
//   green/yellow/red  one-hot registered lamp outputs
//   phase        0 = green, 1 = yellow, 2 = red
//   ped_pending  pedestrian request accepted during the current green
//   tick         high in the cycle the countdown is evaluated
//
// state      | meaning
// PH_GREEN   | green lamp, pedestrian requests accepted
// PH_YELLOW  | yellow lamp
// PH_RED     | red lamp
// PH_ILLEGAL | unreachable; recovers to reset state on the next edge
module traffic_light_timer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV    = 50000000,
   parameter int DIGITS      = 2,
   parameter int GREEN_SEC   = 25,
   parameter int YELLOW_SEC  = 3,
   parameter int RED_SEC     = 30,
   parameter int PED_MIN_SEC = 5
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic                EN,
   input  logic                PED_REQ,
   output logic [4*DIGITS-1:0] digits,
   output logic                green,
   output logic                yellow,
   output logic                red,
   output logic [1:0]          phase,
   output logic                ped_pending,
   output logic                tick
);

   localparam int MAX_SEC = (10 ** DIGITS) - 1;

   if (TICK_DIV < 2) begin : g_chk_div
      $error("TICK_DIV must be at least 2");
   end
   if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_chk_digits
      $error("DIGITS must be 1..4");
   end
   if (GREEN_SEC < 1 || GREEN_SEC > MAX_SEC) begin : g_chk_green
      $error("GREEN_SEC out of range");
   end
   if (YELLOW_SEC < 1 || YELLOW_SEC > MAX_SEC) begin : g_chk_yellow
      $error("YELLOW_SEC out of range");
   end
   if (RED_SEC < 1 || RED_SEC > MAX_SEC) begin : g_chk_red
      $error("RED_SEC out of range");
   end
   if (PED_MIN_SEC < 1 || PED_MIN_SEC > GREEN_SEC) begin : g_chk_ped
      $error("PED_MIN_SEC out of range");
   end

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [4*MAX_DIGITS-1:0] GREEN_BCD  = to_bcd(GREEN_SEC - 1);
   localparam logic [4*MAX_DIGITS-1:0] YELLOW_BCD = to_bcd(YELLOW_SEC - 1);
   localparam logic [4*MAX_DIGITS-1:0] RED_BCD    = to_bcd(RED_SEC - 1);
   localparam logic [4*MAX_DIGITS-1:0] PED_BCD    = to_bcd(PED_MIN_SEC - 1);

   localparam logic [4*DIGITS-1:0] GREEN_LOAD  = GREEN_BCD[4*DIGITS-1:0];
   localparam logic [4*DIGITS-1:0] YELLOW_LOAD = YELLOW_BCD[4*DIGITS-1:0];
   localparam logic [4*DIGITS-1:0] RED_LOAD    = RED_BCD[4*DIGITS-1:0];
   localparam logic [4*DIGITS-1:0] PED_LOAD    = PED_BCD[4*DIGITS-1:0];

   logic [PW-1:0]       r_presc;
   phase_e              r_phase;
   logic                r_green;
   logic                r_yellow;
   logic                r_red;
   logic                r_ped;

   logic                w_tick;
   logic                w_recover;
   logic                w_zero;
   logic                w_ped_acc;
   logic                w_ped_load;
   logic                w_advance;
   logic                w_load;
   logic                w_dec;
   logic [4*DIGITS-1:0] w_bcd;
   logic [4*DIGITS-1:0] w_next_load;
   logic [4*DIGITS-1:0] w_load_val;

   assign w_recover = (r_phase == PH_ILLEGAL);
   // tick is the registered terminal count qualified by EN, so a paused
   // prescaler sitting at its terminal value produces no tick.
   assign w_tick    = EN & (r_presc == PRESC_MAX);

   always_ff @(posedge CLK) begin
      if (CLR || w_recover) begin
         r_presc <= '0;
      end else if (EN) begin
         if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Packed BCD compares the same as binary, so a plain magnitude compare works.
   assign w_ped_acc  = PED_REQ & (r_phase == PH_GREEN);
   assign w_ped_load = w_ped_acc & (w_bcd > PED_LOAD);
   assign w_advance  = w_tick & w_zero & ~w_recover;
   assign w_load     = w_ped_load | w_advance;
   assign w_dec      = w_tick & ~w_zero;

   always_comb begin
      w_next_load = GREEN_LOAD;
      case (r_phase)
         PH_GREEN:  w_next_load = YELLOW_LOAD;
         PH_YELLOW: w_next_load = RED_LOAD;
         default:   w_next_load = GREEN_LOAD;
      endcase
   end

   // A pedestrian load and a phase advance are exclusive: the load needs
   // digits above PED_LOAD, the advance needs digits at zero.
   assign w_load_val = w_ped_load ? PED_LOAD : w_next_load;

   bcd_down_counter #(
      .DIGITS  (DIGITS),
      .RST_VAL (GREEN_LOAD)
   ) u_count (
      .CLK        (CLK),
      .i_clr      (CLR | w_recover),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_bcd      (w_bcd),
      .o_zero     (w_zero)
   );

   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_phase  <= PH_GREEN;
         r_green  <= 1'b1;
         r_yellow <= 1'b0;
         r_red    <= 1'b0;
         r_ped    <= 1'b0;
      end else begin
         case (r_phase)
            PH_GREEN: begin
               if (w_advance) begin
                  r_phase  <= PH_YELLOW;
                  r_green  <= 1'b0;
                  r_yellow <= 1'b1;
                  r_ped    <= 1'b0;
               end else if (w_ped_acc) begin
                  r_ped    <= 1'b1;
               end
            end
            PH_YELLOW: begin
               if (w_advance) begin
                  r_phase  <= PH_RED;
                  r_yellow <= 1'b0;
                  r_red    <= 1'b1;
               end
            end
            PH_RED: begin
               if (w_advance) begin
                  r_phase  <= PH_GREEN;
                  r_red    <= 1'b0;
                  r_green  <= 1'b1;
               end
            end
            default: begin
               r_phase  <= PH_GREEN;
               r_green  <= 1'b1;
               r_yellow <= 1'b0;
               r_red    <= 1'b0;
               r_ped    <= 1'b0;
            end
         endcase
      end
   end

   assign digits      = w_bcd;
   assign green       = r_green;
   assign yellow      = r_yellow;
   assign red         = r_red;
   assign phase       = r_phase;
   assign ped_pending = r_ped;
   assign tick        = w_tick;

endmodule

// File: tb/tb_traffic_light_timer.sv
// Randomised and directed bench for traffic_light_timer against an
// integer seconds-remaining reference model.
module tb_traffic_light_timer;

   localparam int TICK_DIV    = 4;
   localparam int DIGITS      = 2;
   localparam int GREEN_SEC   = 12;
   localparam int YELLOW_SEC  = 3;
   localparam int RED_SEC     = 10;
   localparam int PED_MIN_SEC = 5;

   logic       CLK;
   logic       CLR;
   logic       EN;
   logic       PED_REQ;
   logic [7:0] digits;
   logic       green;
   logic       yellow;
   logic       red;
   logic [1:0] phase;
   logic       ped_pending;
   logic       tick;

   traffic_light_timer #(
      .TICK_DIV    (TICK_DIV),
      .DIGITS      (DIGITS),
      .GREEN_SEC   (GREEN_SEC),
      .YELLOW_SEC  (YELLOW_SEC),
      .RED_SEC     (RED_SEC),
      .PED_MIN_SEC (PED_MIN_SEC)
   ) dut (
      .CLK         (CLK),
      .CLR         (CLR),
      .EN          (EN),
      .PED_REQ     (PED_REQ),
      .digits      (digits),
      .green       (green),
      .yellow      (yellow),
      .red         (red),
      .phase       (phase),
      .ped_pending (ped_pending),
      .tick        (tick)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase index, whole seconds remaining, prescaler count.
   int m_presc = 0;
   int m_ph    = 0;
   int m_rem   = GREEN_SEC - 1;
   int m_ped   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int dur(input int p);
      if (p == 0) return GREEN_SEC;
      if (p == 1) return YELLOW_SEC;
      return RED_SEC;
   endfunction

   function automatic logic [31:0] to_bcd8(input int v);
      return 32'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic model_edge(input logic en, input logic clr, input logic req);
      bit tk;
      bit acc;
      tk = en && (m_presc == TICK_DIV - 1);
      if (clr) begin
         m_presc = 0;
         m_ph    = 0;
         m_rem   = GREEN_SEC - 1;
         m_ped   = 0;
      end else begin
         if (en) m_presc = (m_presc + 1) % TICK_DIV;
         acc = (m_ph == 0) && req;
         if (acc) m_ped = 1;
         if (acc && m_rem > PED_MIN_SEC - 1) begin
            m_rem = PED_MIN_SEC - 1;
         end else if (tk) begin
            if (m_rem > 0) begin
               m_rem--;
            end else begin
               m_ph  = (m_ph + 1) % 3;
               m_rem = dur(m_ph) - 1;
               if (m_ph == 1) m_ped = 0;
            end
         end
      end
   endtask

   // Called at a negedge: drive, check tick, clock, then check registered outputs.
   task automatic step(input logic en, input logic clr, input logic req);
      EN      = en;
      CLR     = clr;
      PED_REQ = req;
      #1;
      if (!clr) chk("tick", 32'(tick), 32'(en && (m_presc == TICK_DIV - 1)));
      @(posedge CLK);
      model_edge(en, clr, req);
      @(negedge CLK);
      chk("digits", 32'(digits), to_bcd8(m_rem));
      chk("phase", 32'(phase), 32'(m_ph));
      chk("green", 32'(green), 32'(m_ph == 0));
      chk("yellow", 32'(yellow), 32'(m_ph == 1));
      chk("red", 32'(red), 32'(m_ph == 2));
      chk("ped_pending", 32'(ped_pending), 32'(m_ped));
   endtask

   task automatic run_until(input int ph, input int rem, input int max_cyc);
      int n;
      n = 0;
      while (!(m_ph == ph && m_rem == rem) && n < max_cyc) begin
         step(1'b1, 1'b0, 1'b0);
         n++;
      end
      if (n >= max_cyc) chk("reach_target", 32'(0), 32'(1));
   endtask

   initial begin
      EN      = 1'b0;
      CLR     = 1'b0;
      PED_REQ = 1'b0;

      // Reset
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("rst_digits", 32'(digits), 32'h11);
      chk("rst_green", 32'(green), 32'(1));
      chk("rst_tick", 32'(tick), 32'(0));

      // BCD borrow 0x10 -> 0x09 with green still lit
      run_until(0, 9, 100);
      chk("borrow_digits", 32'(digits), 32'h09);
      chk("borrow_green", 32'(green), 32'(1));

      // Full cycle back to green start
      run_until(1, 2, 200);
      run_until(2, 9, 200);
      run_until(0, 11, 200);
      chk("wrap_digits", 32'(digits), 32'h11);

      // Pedestrian: shorten at 8, no change at 3, ignored in red
      run_until(0, 8, 200);
      step(1'b1, 1'b0, 1'b1);
      chk("ped_short", 32'(digits), 32'h04);
      chk("ped_set", 32'(ped_pending), 32'(1));
      run_until(0, 3, 200);
      step(1'b1, 1'b0, 1'b1);
      chk("ped_noshort", 32'(digits), 32'h03);
      run_until(2, 5, 200);
      step(1'b1, 1'b0, 1'b1);
      chk("ped_red", 32'(ped_pending), 32'(0));

      // Pause mid-yellow with prescaler part-way through
      run_until(1, 1, 200);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
      chk("pause_digits", 32'(digits), 32'h01);
      chk("pause_phase", 32'(phase), 32'(1));
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

      // Reset mid-red
      run_until(2, 6, 200);
      step(1'b1, 1'b1, 1'b0);
      chk("midrst_digits", 32'(digits), 32'h11);
      chk("midrst_green", 32'(green), 32'(1));
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_timer.md
# traffic_light_timer

Parametrised three-phase (green → yellow → red) traffic-light timer with an N-digit BCD countdown of seconds remaining in the current phase. The block has a built-in tick prescaler, a pause input and a pedestrian request that shortens the green phase. It sits between the board clock and the BCD-to-7-segment decoders and lamp outputs in the board top level.

## Interface
- TICK_DIV, 50000000: CLK cycles per countdown tick (1 s at 50 MHz); ≥ 2.
- DIGITS, 2: number of BCD digits in the countdown; 1..4.
- GREEN_SEC, 25: green phase length in ticks; 1..10^DIGITS-1.
- YELLOW_SEC, 3: yellow phase length in ticks; same range as GREEN_SEC.
- RED_SEC, 30: red phase length in ticks; same range as GREEN_SEC.
- PED_MIN_SEC, 5: green ticks remaining after a pedestrian request; 1..GREEN_SEC.
- CLK  in  1  system clock; the only clock.
- CLR  in  1  reset; synchronous, active-high.
- EN  in  1  run enable; 0 freezes the prescaler and the countdown.
- PED_REQ  in  1  pedestrian request; level-sampled on every CLK edge.
- digits  out  4*DIGITS  BCD seconds remaining; digit 0 in [3:0], least significant.
- green, yellow, red  out  1 each  lamp outputs; exactly one is high.
- phase  out  2  current phase: 0 = GREEN, 1 = YELLOW, 2 = RED.
- ped_pending  out  1  pedestrian request accepted in the current green phase.
- tick  out  1  one-cycle pulse when the countdown is evaluated.

## Operation
- **Prescaler:** counts 0..TICK_DIV-1 while EN=1 and holds its value while EN=0. `tick` is high for the cycle in which prescaler = TICK_DIV-1 and EN=1; the prescaler wraps to 0 on the next edge.
- **Countdown:** on entering a phase of length D, `digits` is loaded with BCD(D-1). On each tick:
  - digits ≠ 0: decrement with BCD borrow. A digit at 0 becomes 9 and borrows from the next digit up.
  - digits = 0: advance phase GREEN→YELLOW→RED→GREEN and load the new phase's D-1.
  - Result: each phase lasts exactly D ticks. Phase code 3 is illegal; if reached, recover to the reset state on the next edge.
- **Lamps:** one-hot, decoded from the registered phase and registered themselves.
- **Pedestrian request:** accepted only when phase = GREEN and PED_REQ = 1.
  - On acceptance, set ped_pending.
  - If digits > BCD(PED_MIN_SEC-1), load digits with BCD(PED_MIN_SEC-1), replacing any decrement in the same cycle. Otherwise digits are unchanged.
  - Accepted even when EN = 0.
  - Ignored in YELLOW and RED.
  - ped_pending clears on the GREEN→YELLOW transition.
- **Reset values (CLR=1):** prescaler 0, phase GREEN, digits BCD(GREEN_SEC-1), green 1, yellow 0, red 0, ped_pending 0, tick 0.
- **Parameter checks:** elaboration fails on any out-of-range parameter value.

## Timing
- All outputs are registered. Phase, lamps and digits change on the edge that samples tick = 1.
- Pedestrian shortening takes effect on the edge after PED_REQ is sampled high, i.e. one-cycle latency.
- CLR has priority over EN, PED_REQ and tick. Asserting CLR mid-phase gives the reset state on the next edge; the count restarts from a fresh prescaler period.
- EN deasserted: digits, phase and prescaler are frozen and tick = 0. On reassertion, timing resumes with no lost or extra cycles.

## Structure
- **Shared package `traffic_pkg`:** phase encoding constants, and an elaboration-time binary-to-BCD function used to form the load constants.
- **Sub-module `bcd_down_counter`:** DIGITS-parametrised, with load, load value, decrement enable, zero flag and BCD output.
- **Top-level logic:** prescaler, phase FSM and pedestrian logic stay in traffic_light_timer.

## Test plan
Bench parameters: TICK_DIV=4, DIGITS=2, GREEN_SEC=12, YELLOW_SEC=3, RED_SEC=10, PED_MIN_SEC=5.
- **Reset:** CLR high for 2 cycles → digits=0x11, green=1, yellow=red=0, phase=0, tick=0, ped_pending=0.
- **Full cycle:** EN=1 throughout → tick every 4 cycles. Green shows 0x11..0x00 for 48 cycles, then yellow 0x02..0x00, red 0x09..0x00, then green 0x11.
- **BCD borrow:** at digits=0x10, next tick → 0x09; green is still high.
- **Pedestrian request:**
  - PED_REQ one cycle at green digits=0x08 → next edge digits=0x04, ped_pending=1.
  - Request at digits=0x03 → no change.
  - Request in red → ignored, ped_pending=0.
- **Pause:** EN=0 for 20 cycles mid-yellow → digits, phase and prescaler unchanged, tick=0. After EN=1, the next tick arrives after the remaining prescaler count.
- **Reset mid-operation:** CLR pulse during red at digits=0x06 → next edge digits=0x11, green=1, prescaler restarted.
